sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001: Parameter DATA_WIDTH, default 16, width of each stored word in bits.
REQ-002: Parameter FIFO_DEPTH, default 8, number of storage entries; SHALL be a power of two and >= 2.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-high.
REQ-005: wr_en  input  1  push request, sampled on rising clk edge.
REQ-006: wr_data  input  DATA_WIDTH  word to push, sampled with wr_en.
REQ-007: rd_en  input  1  pop request, sampled on rising clk edge.
REQ-008: rd_data  output  DATA_WIDTH  head-of-queue word (show-ahead).
REQ-009: full  output  1  high when occupancy == FIFO_DEPTH.
REQ-010: empty  output  1  high when occupancy == 0.
REQ-011: count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-012: overflow  output  1  one-cycle pulse: push was rejected because the FIFO was full.
REQ-013: underflow  output  1  one-cycle pulse: pop was rejected because the FIFO was empty.

Function
REQ-014: Storage SHALL be FIFO_DEPTH x DATA_WIDTH, with a write index, a read index and an occupancy counter; both indices wrap from FIFO_DEPTH-1 to 0.
REQ-015: A push SHALL be accepted on a rising edge when wr_en=1 and full=0 (pre-edge value); wr_data goes to the write index, which then advances by one.
REQ-016: A pop SHALL be accepted on a rising edge when rd_en=1 and empty=0 (pre-edge value); the read index then advances by one.
REQ-017: rd_data SHALL be driven combinationally from the entry at the read index, so the head word is valid whenever empty=0, before rd_en is asserted; the consumer samples rd_data in the same cycle it asserts rd_en.
REQ-018: When empty=1, rd_data SHALL hold the last value at the read index; its content is don't-care.
REQ-019: Occupancy SHALL change by +1 for a push alone, -1 for a pop alone, and 0 when both are accepted in the same cycle.
REQ-020: full, empty and count SHALL be derived from the registered occupancy and SHALL reflect an accepted operation immediately after the edge that performs it (zero added latency).
REQ-021: When full=1, a push SHALL be dropped even if rd_en=1 in the same cycle; the pop SHALL still proceed, so full falls to 0.
REQ-022: When empty=1, a pop SHALL be ignored even if wr_en=1 in the same cycle; the push SHALL still proceed, so empty falls to 0.
REQ-023: overflow SHALL be registered high for one cycle after an edge with wr_en=1 and full=1; underflow likewise for rd_en=1 and empty=1.
REQ-024: Data SHALL emerge in exactly push order, including across index wrap-around.
REQ-025: full and empty SHALL never be high simultaneously.

Reset
REQ-026: While rst=1, asynchronously: indices=0, count=0, empty=1, full=0, overflow=0, underflow=0; storage contents need not be cleared.
REQ-027: Reset asserted mid-operation SHALL discard all queued data; a pop request pending in the same cycle SHALL have no effect.
REQ-028: After rst deasserts, the first rising edge SHALL accept operations normally.

Verification
REQ-029: Reset 5 cycles, release -> empty=1, full=0, count=0.
REQ-030: 16 iterations: push random word, then pop it -> each popped word equals the pushed word; empty=1 at end; the indices wrap twice.
REQ-031: Push 8 words D0..D7 -> full=1, empty=0, count=8; a 9th push with full=1 -> dropped, overflow pulses, count stays 8.
REQ-032: From full: pop (returns D0), then push D8 -> full=1 again; then 8 pops return D1..D7 and D8 in order -> empty=1.
REQ-033: From empty: rd_en held 5 cycles -> no pop, underflow pulses; then push X -> next cycle empty=0, rd_data=X; pop -> returns X, empty=1.
REQ-034: Push 3 words, then assert rst mid-cycle (asynchronously) -> empty=1, count=0 immediately, and the next push/pop pair returns the new word.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Push/pop bundle between a FIFO and its producer/consumer.
// Latency: none; pure wiring.
// Backpressure: consumer watches full/empty; rejected requests raise overflow/underflow.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side: issues requests, observes status and head word.
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, count, overflow, underflow
  );

  // FIFO side: accepts requests, drives status and head word.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO, FIFO_DEPTH x DATA_WIDTH (FIFO_DEPTH a power of two, >= 2).
// Latency: push visible on rd_data/count one edge later; head word is combinational.
// Backpressure: push dropped while full, pop ignored while empty; each flags a 1-cycle pulse.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave fif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full;
  logic empty;
  logic wr_accept;
  logic rd_accept;

  // Status comes straight from the registered occupancy, so it tracks each edge with no lag.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Acceptance uses pre-edge status: a full FIFO drops a push even when a pop frees a slot.
  assign wr_accept = fif.wr_en && !full;
  assign rd_accept = fif.rd_en && !empty;

  // Next-state for indices, occupancy and the reject pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = fif.wr_en && full;
    underflow_d = fif.rd_en && empty;

    // Power-of-two depth lets the indices wrap by natural overflow.
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset clears occupancy so any queued data is discarded at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are left as-is on reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) mem_q[wr_ptr_q] <= fif.wr_data;
  end

  assign fif.rd_data   = mem_q[rd_ptr_q];
  assign fif.full      = full;
  assign fif.empty     = empty;
  assign fif.count     = count_q;
  assign fif.overflow  = overflow_q;
  assign fif.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, wrap, fill/overflow, refill, underflow, simultaneous ops, mid-run reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench checks that rejected requests pulse overflow/underflow and leave state intact.
module tb_sync_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) fif ();

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fif.wr_en = 1'b0; fif.rd_en = 1'b0; fif.wr_data = '0;
    rst = 1'b1;
    repeat (5) tick();
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL rst_hold_empty: got %b expected 1", fif.empty); end
    checks++; if (fif.overflow !== 1'b0 || fif.underflow !== 1'b0) begin errors++; $display("FAIL rst_hold_pulses: got ovf=%b unf=%b expected 0/0", fif.overflow, fif.underflow); end
    rst = 1'b0;
    tick();
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", fif.empty); end
    checks++; if (fif.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", fif.full); end
    checks++; if (fif.count !== CW'(0)) begin errors++; $display("FAIL rst_count: got %0d expected 0", fif.count); end
  endtask

  task automatic test_push_pop_wrap();
    logic [DW-1:0] w;
    for (int i = 0; i < 16; i++) begin
      w = 16'(16'hA50F + i * 16'h0123);
      fif.wr_en = 1'b1; fif.wr_data = w;
      tick();
      fif.wr_en = 1'b0;
      checks++; if (fif.empty !== 1'b0 || fif.count !== CW'(1)) begin errors++; $display("FAIL wrap_push[%0d]: got empty=%b count=%0d expected 0/1", i, fif.empty, fif.count); end
      checks++; if (fif.rd_data !== w) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, fif.rd_data, w); end
      fif.rd_en = 1'b1;
      tick();
      fif.rd_en = 1'b0;
    end
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL wrap_end_empty: got %b expected 1", fif.empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      fif.wr_en = 1'b1; fif.wr_data = 16'(16'hD000 + i);
      tick();
      checks++; if (fif.count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fif.count, i + 1); end
    end
    fif.wr_en = 1'b0;
    checks++; if (fif.full !== 1'b1 || fif.empty !== 1'b0) begin errors++; $display("FAIL fill_flags: got full=%b empty=%b expected 1/0", fif.full, fif.empty); end
    checks++; if (fif.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b expected 0", fif.overflow); end
    fif.wr_en = 1'b1; fif.wr_data = 16'hDEAD;
    tick();
    fif.wr_en = 1'b0;
    checks++; if (fif.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", fif.overflow); end
    checks++; if (fif.count !== CW'(8) || fif.full !== 1'b1) begin errors++; $display("FAIL ovf_count: got count=%0d full=%b expected 8/1", fif.count, fif.full); end
    tick();
    checks++; if (fif.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", fif.overflow); end
    checks++; if (fif.rd_data !== 16'hD000) begin errors++; $display("FAIL ovf_head: got %h expected d000", fif.rd_data); end
  endtask

  task automatic test_full_pop_push();
    logic [DW-1:0] exp_q [8];
    for (int i = 0; i < 8; i++) exp_q[i] = 16'(16'hD001 + i);
    fif.rd_en = 1'b1;
    checks++; if (fif.rd_data !== 16'hD000) begin errors++; $display("FAIL refill_pop0: got %h expected d000", fif.rd_data); end
    tick();
    fif.rd_en = 1'b0;
    checks++; if (fif.full !== 1'b0 || fif.count !== CW'(7)) begin errors++; $display("FAIL refill_after_pop: got full=%b count=%0d expected 0/7", fif.full, fif.count); end
    fif.wr_en = 1'b1; fif.wr_data = 16'hD008;
    tick();
    fif.wr_en = 1'b0;
    checks++; if (fif.full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b expected 1", fif.full); end
    for (int i = 0; i < 8; i++) begin
      fif.rd_en = 1'b1;
      checks++; if (fif.rd_data !== exp_q[i]) begin errors++; $display("FAIL refill_order[%0d]: got %h expected %h", i, fif.rd_data, exp_q[i]); end
      tick();
    end
    fif.rd_en = 1'b0;
    checks++; if (fif.empty !== 1'b1 || fif.count !== CW'(0)) begin errors++; $display("FAIL refill_drain: got empty=%b count=%0d expected 1/0", fif.empty, fif.count); end
  endtask

  task automatic test_underflow();
    fif.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (fif.underflow !== 1'b1 || fif.count !== CW'(0) || fif.empty !== 1'b1) begin errors++; $display("FAIL unf_hold[%0d]: got unf=%b count=%0d empty=%b expected 1/0/1", i, fif.underflow, fif.count, fif.empty); end
    end
    fif.rd_en = 1'b0;
    tick();
    checks++; if (fif.underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", fif.underflow); end
    fif.wr_en = 1'b1; fif.wr_data = 16'h5A5A;
    tick();
    fif.wr_en = 1'b0;
    checks++; if (fif.empty !== 1'b0 || fif.rd_data !== 16'h5A5A) begin errors++; $display("FAIL unf_push: got empty=%b data=%h expected 0/5a5a", fif.empty, fif.rd_data); end
    fif.rd_en = 1'b1;
    tick();
    fif.rd_en = 1'b0;
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL unf_pop: got empty=%b expected 1", fif.empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      fif.wr_en = 1'b1; fif.wr_data = 16'(16'hE000 + i);
      tick();
    end
    // Full: push must be dropped while the pop still goes through.
    fif.wr_en = 1'b1; fif.rd_en = 1'b1; fif.wr_data = 16'hBEEF;
    tick();
    fif.wr_en = 1'b0; fif.rd_en = 1'b0;
    checks++; if (fif.overflow !== 1'b1 || fif.full !== 1'b0 || fif.count !== CW'(7)) begin errors++; $display("FAIL sim_full: got ovf=%b full=%b count=%0d expected 1/0/7", fif.overflow, fif.full, fif.count); end
    checks++; if (fif.rd_data !== 16'hE001) begin errors++; $display("FAIL sim_full_head: got %h expected e001", fif.rd_data); end
    // Mid-level: push and pop together leave occupancy unchanged.
    fif.wr_en = 1'b1; fif.rd_en = 1'b1; fif.wr_data = 16'hE008;
    tick();
    fif.wr_en = 1'b0; fif.rd_en = 1'b0;
    checks++; if (fif.count !== CW'(7) || fif.rd_data !== 16'hE002) begin errors++; $display("FAIL sim_mid: got count=%0d head=%h expected 7/e002", fif.count, fif.rd_data); end
    fif.rd_en = 1'b1;
    repeat (7) tick();
    fif.rd_en = 1'b0;
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL sim_drain: got empty=%b expected 1", fif.empty); end
    // Empty: pop must be ignored while the push still goes through.
    fif.wr_en = 1'b1; fif.rd_en = 1'b1; fif.wr_data = 16'hC0DE;
    tick();
    fif.wr_en = 1'b0; fif.rd_en = 1'b0;
    checks++; if (fif.underflow !== 1'b1 || fif.count !== CW'(1) || fif.rd_data !== 16'hC0DE) begin errors++; $display("FAIL sim_empty: got unf=%b count=%0d head=%h expected 1/1/c0de", fif.underflow, fif.count, fif.rd_data); end
    fif.rd_en = 1'b1;
    tick();
    fif.rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      fif.wr_en = 1'b1; fif.wr_data = 16'(16'h7100 + i);
      tick();
    end
    fif.wr_en = 1'b0;
    checks++; if (fif.count !== CW'(3)) begin errors++; $display("FAIL rmid_pre: got count=%0d expected 3", fif.count); end
    fif.rd_en = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (fif.empty !== 1'b1 || fif.count !== CW'(0) || fif.full !== 1'b0) begin errors++; $display("FAIL rmid_async: got empty=%b count=%0d full=%b expected 1/0/0", fif.empty, fif.count, fif.full); end
    tick();
    fif.rd_en = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (fif.empty !== 1'b1 || fif.underflow !== 1'b0) begin errors++; $display("FAIL rmid_release: got empty=%b unf=%b expected 1/0", fif.empty, fif.underflow); end
    fif.wr_en = 1'b1; fif.wr_data = 16'h9ABC;
    tick();
    fif.wr_en = 1'b0;
    checks++; if (fif.rd_data !== 16'h9ABC || fif.count !== CW'(1)) begin errors++; $display("FAIL rmid_new: got head=%h count=%0d expected 9abc/1", fif.rd_data, fif.count); end
    fif.rd_en = 1'b1;
    tick();
    fif.rd_en = 1'b0;
    checks++; if (fif.empty !== 1'b1) begin errors++; $display("FAIL rmid_pop: got empty=%b expected 1", fif.empty); end
  endtask

  initial begin
    test_reset();
    test_push_pop_wrap();
    test_fill_overflow();
    test_full_pop_push();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
